// File: rtl/rom_cache_pkg.sv
// Shared types and helpers for the ROM fetch cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_cache_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOOKUP,
        FILL
    } state_t;

    localparam int DATA_W     = 64;
    localparam int MAX_ADDR_W = 32;

    // Tag portion of a word address: everything above the line index.
    function automatic logic [MAX_ADDR_W-1:0] tag_of(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int                    idx_bits);
        return addr >> idx_bits;
    endfunction

endpackage

// File: rtl/rom_cache_ram.sv
// Simple dual-port line store, one write port and one registered read port.
// Latency: read data appears the cycle after the address is presented.
// Backpressure: none; both ports accept every cycle.
module rom_cache_ram #(
    parameter int AW = 8,
    parameter int DW = 77
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:DEPTH-1];

    // Write port: contents are only meaningful after the controller's clear sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/rom_cache.sv
// Direct-mapped one-word-per-line read cache between core ROM fetch and DDR3.
// Latency: hit acks 2 cycles after the request is seen; miss acks 1 cycle after DDR3 ack.
// Backpressure: toggle req/ack on both sides; one outstanding each; new core requests wait for IDLE.
module rom_cache
    import rom_cache_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int IDX_BITS = 8
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    input  logic              INVALIDATE,
    input  logic [ADDR_W-1:0] ROM_ADDR,
    input  logic              ROM_REQ,
    output logic              ROM_ACK,
    output logic [DATA_W-1:0] ROM_DATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_REQ,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              BUSY
);

    localparam int TAG_W  = ADDR_W - IDX_BITS;
    localparam int LINE_W = 1 + TAG_W + DATA_W;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic [IDX_BITS-1:0] clr_eff;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rom_ack_q, rom_ack_d;
    logic                mem_req_q, mem_req_d;
    logic [DATA_W-1:0]   rom_data_q, rom_data_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                inval_q;
    logic                inval_seen_q, inval_seen_d;

    logic                ram_we;
    logic [IDX_BITS-1:0] ram_waddr;
    logic [LINE_W-1:0]   ram_wdata;
    logic [LINE_W-1:0]   ram_rdata;

    logic                line_valid;
    logic [TAG_W-1:0]    line_tag;
    logic [DATA_W-1:0]   line_data;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic                req_pending;

    // The read port always follows the live core address; it is only consumed in LOOKUP.
    rom_cache_ram #(
        .AW (IDX_BITS),
        .DW (LINE_W)
    ) u_ram (
        .clk   (MCLK),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ROM_ADDR[IDX_BITS-1:0]),
        .rdata (ram_rdata)
    );

    assign line_valid  = ram_rdata[LINE_W-1];
    assign line_tag    = ram_rdata[LINE_W-2 -: TAG_W];
    assign line_data   = ram_rdata[DATA_W-1:0];
    assign req_tag     = TAG_W'(tag_of(MAX_ADDR_W'(addr_q), IDX_BITS));
    assign hit         = line_valid && (line_tag == req_tag);
    assign req_pending = (ROM_REQ != rom_ack_q);

    // The sweep restarts at index 0 on the first cycle INVALIDATE is low again, so a full
    // pass always follows the end of a download regardless of where the wrap had got to.
    assign clr_eff = (inval_q && !INVALIDATE) ? '0 : clr_cnt_q;

    assign ROM_ACK  = rom_ack_q;
    assign ROM_DATA = rom_data_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_REQ  = mem_req_q;
    assign BUSY     = (state_q == CLEAR);

    // Next-state, handshake toggles and line-store write control.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        addr_d       = addr_q;
        rom_ack_d    = rom_ack_q;
        mem_req_d    = mem_req_q;
        rom_data_d   = rom_data_q;
        mem_addr_d   = mem_addr_q;
        inval_seen_d = inval_seen_q;
        ram_we       = 1'b0;
        ram_waddr    = clr_eff;
        ram_wdata    = '0;

        case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_eff;
                ram_wdata = '0;
                clr_cnt_d = clr_eff + IDX_BITS'(1);
                if ((clr_eff == '1) && !INVALIDATE) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (INVALIDATE) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (req_pending) begin
                    addr_d  = ROM_ADDR;
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                if (INVALIDATE) begin
                    // Request stays pending and is looked up again after the sweep.
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (hit) begin
                    rom_data_d = line_data;
                    rom_ack_d  = ~rom_ack_q;
                    state_d    = IDLE;
                end else begin
                    mem_addr_d   = addr_q;
                    mem_req_d    = ~mem_req_q;
                    inval_seen_d = 1'b0;
                    state_d      = FILL;
                end
            end

            FILL: begin
                if (INVALIDATE) begin
                    inval_seen_d = 1'b1;
                end
                if (MEM_ACK == mem_req_q) begin
                    rom_data_d = MEM_DATA;
                    rom_ack_d  = ~rom_ack_q;
                    if (INVALIDATE || inval_seen_q) begin
                        // Data may predate the new image: deliver it but do not cache it.
                        state_d      = CLEAR;
                        clr_cnt_d    = '0;
                        inval_seen_d = 1'b0;
                    end else begin
                        ram_we    = 1'b1;
                        ram_waddr = addr_q[IDX_BITS-1:0];
                        ram_wdata = {1'b1, req_tag, MEM_DATA};
                        state_d   = IDLE;
                    end
                end
            end

            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // State and handshake registers.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            addr_q       <= '0;
            rom_ack_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            rom_data_q   <= '0;
            mem_addr_q   <= '0;
            inval_q      <= 1'b0;
            inval_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            addr_q       <= addr_d;
            rom_ack_q    <= rom_ack_d;
            mem_req_q    <= mem_req_d;
            rom_data_q   <= rom_data_d;
            mem_addr_q   <= mem_addr_d;
            inval_q      <= INVALIDATE;
            inval_seen_q <= inval_seen_d;
        end
    end

endmodule

// File: tb/tb_rom_cache.sv
// Bench for rom_cache: vector table, hand-written flush/invalidate sequences, random traffic.
// Latency: checks exact hit/miss/flush cycle counts.
// Backpressure: DDR3 model with fixed or random 1-30 cycle ack latency.
module tb_rom_cache;

    logic        MCLK = 1'b0;
    logic        RESET_N;
    logic        INVALIDATE;
    logic [19:0] ROM_ADDR;
    logic        ROM_REQ;
    logic        ROM_ACK;
    logic [63:0] ROM_DATA;
    logic [19:0] MEM_ADDR;
    logic        MEM_REQ;
    logic        MEM_ACK;
    logic [63:0] MEM_DATA;
    logic        BUSY;

    rom_cache #(.ADDR_W(20), .IDX_BITS(8)) dut (
        .MCLK       (MCLK),
        .RESET_N    (RESET_N),
        .INVALIDATE (INVALIDATE),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_REQ    (ROM_REQ),
        .ROM_ACK    (ROM_ACK),
        .ROM_DATA   (ROM_DATA),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_REQ    (MEM_REQ),
        .MEM_ACK    (MEM_ACK),
        .MEM_DATA   (MEM_DATA),
        .BUSY       (BUSY)
    );

    always #5 MCLK = ~MCLK;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          req_cyc = 0;
    int          n_req = 0;
    int          ack_cnt = 0;
    logic        ack_seen = 1'b0;
    logic [63:0] exp_q[$];

    int          ddr_lat = 3;
    bit          ddr_rand = 1'b0;
    int          mem_toggles = 0;
    logic [19:0] last_mem_addr = '0;
    int          addr_unstable = 0;

    always @(posedge MCLK) cyc <= cyc + 1;

    function automatic logic [63:0] ddr_word(input logic [19:0] a);
        if (a == 20'h12345) return 64'hDEADBEEF_01234567;
        return {12'hC0D, a, ~a, 12'h5A3};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // DDR3 read model: answers each MEM_REQ toggle after the configured latency.
    initial begin
        int lat;
        MEM_ACK  = 1'b0;
        MEM_DATA = '0;
        forever begin
            @(posedge MCLK); #1;
            if (RESET_N && (MEM_REQ != MEM_ACK)) begin
                mem_toggles++;
                last_mem_addr = MEM_ADDR;
                lat = ddr_rand ? int'($urandom_range(1, 30)) : ddr_lat;
                repeat (lat) begin
                    @(posedge MCLK); #1;
                    if (MEM_ADDR != last_mem_addr) addr_unstable++;
                end
                MEM_DATA = ddr_word(MEM_ADDR);
                MEM_ACK  = MEM_REQ;
            end
        end
    end

    // Scoreboard: every ROM_ACK toggle pops one expected word.
    initial begin
        forever begin
            @(negedge MCLK);
            if (RESET_N && (ROM_ACK != ack_seen)) begin
                ack_seen = ROM_ACK;
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack with data 0x%0h, expected no ack", ROM_DATA);
                end else begin
                    check("rom_data", ROM_DATA, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [19:0] a);
        @(posedge MCLK); #1;
        ROM_ADDR = a;
        ROM_REQ  = ~ROM_REQ;
        req_cyc  = cyc;
        n_req++;
        exp_q.push_back(ddr_word(a));
    endtask

    task automatic wait_ack(output int lat);
        int n;
        n = 0;
        while ((ROM_ACK != ROM_REQ) && (n < 3000)) begin
            @(negedge MCLK);
            n++;
        end
        lat = cyc - req_cyc;
        if (ROM_ACK != ROM_REQ) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: no ack after %0d cycles, expected ack", n);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && (n < 3000)) begin
            @(negedge MCLK);
            n++;
        end
        if (BUSY) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: BUSY still 1 after %0d cycles, expected 0", n);
        end
    endtask

    typedef struct {
        logic [19:0] addr;
        logic [63:0] exp_data;
        int          exp_miss;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat;
        int rel;
        int busy_n;
        int mt0;
        int f_cyc;
        int acks0;

        // Table: with ddr_lat = 3 a miss acks 3 + 3 cycles after the request, a hit 2.
        vecs[0] = '{20'h12345, ddr_word(20'h12345), 1, 6};
        vecs[1] = '{20'h12345, ddr_word(20'h12345), 0, 2};
        vecs[2] = '{20'h00100, ddr_word(20'h00100), 1, 6};
        vecs[3] = '{20'h00200, ddr_word(20'h00200), 1, 6};
        vecs[4] = '{20'h00100, ddr_word(20'h00100), 1, 6};
        vecs[5] = '{20'h12345, ddr_word(20'h12345), 0, 2};
        vecs[6] = '{20'h00010, ddr_word(20'h00010), 0, 2};

        RESET_N    = 1'b0;
        INVALIDATE = 1'b0;
        ROM_ADDR   = '0;
        ROM_REQ    = 1'b0;

        repeat (3) @(posedge MCLK);
        @(negedge MCLK);
        check("reset_busy", 64'(BUSY), 64'd1);
        check("reset_rom_ack", 64'(ROM_ACK), 64'd0);
        check("reset_mem_req", 64'(MEM_REQ), 64'd0);
        check("reset_rom_data", ROM_DATA, 64'd0);
        check("reset_mem_addr", 64'(MEM_ADDR), 64'd0);

        // Release reset and request 0x00010 while the flush is running.
        @(posedge MCLK); #1;
        RESET_N  = 1'b1;
        rel      = cyc;
        ROM_ADDR = 20'h00010;
        ROM_REQ  = ~ROM_REQ;
        req_cyc  = cyc;
        n_req++;
        exp_q.push_back(ddr_word(20'h00010));
        busy_n = 0;
        while (BUSY && (busy_n < 2000)) begin
            @(negedge MCLK);
            if (BUSY) busy_n++;
        end
        check("flush_cycles", 64'(busy_n), 64'd256);
        check("no_ack_during_flush", 64'(ack_cnt), 64'd0);
        wait_ack(lat);
        check("flush_then_miss_lat", 64'(cyc - rel), 64'd262);
        check("flush_miss_toggles", 64'(mem_toggles), 64'd1);
        check("flush_miss_mem_addr", 64'(last_mem_addr), 64'h00010);

        // Table-driven miss/hit/conflict vectors.
        for (int i = 0; i < 7; i++) begin
            mt0 = mem_toggles;
            @(posedge MCLK); #1;
            ROM_ADDR = vecs[i].addr;
            ROM_REQ  = ~ROM_REQ;
            req_cyc  = cyc;
            n_req++;
            exp_q.push_back(vecs[i].exp_data);
            wait_ack(lat);
            check($sformatf("vec%0d_mem_toggles", i), 64'(mem_toggles - mt0), 64'(vecs[i].exp_miss));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // INVALIDATE pulse during a slow fill: data still delivered, line not kept.
        ddr_lat = 20;
        mt0 = mem_toggles;
        issue(20'h00055);
        repeat (5) @(posedge MCLK);
        #1 INVALIDATE = 1'b1;
        repeat (3) @(posedge MCLK);
        #1 INVALIDATE = 1'b0;
        wait_ack(lat);
        check("inval_fill_latency", 64'(lat), 64'd23);
        check("inval_fill_busy_after", 64'(BUSY), 64'd1);
        wait_idle();
        ddr_lat = 3;
        issue(20'h00055);
        wait_ack(lat);
        check("inval_fill_refetch_toggles", 64'(mem_toggles - mt0), 64'd2);
        check("inval_fill_refetch_lat", 64'(lat), 64'd6);

        // INVALIDATE held for 1000 cycles with a request pending.
        @(posedge MCLK); #1;
        INVALIDATE = 1'b1;
        repeat (4) @(posedge MCLK);
        mt0   = mem_toggles;
        acks0 = ack_cnt;
        issue(20'h12345);
        repeat (995) @(posedge MCLK);
        @(negedge MCLK);
        check("hold_no_ack", 64'(ack_cnt - acks0), 64'd0);
        check("hold_busy", 64'(BUSY), 64'd1);
        @(posedge MCLK); #1;
        INVALIDATE = 1'b0;
        f_cyc = cyc;
        wait_ack(lat);
        check("hold_release_lat", 64'(cyc - f_cyc), 64'd262);
        check("hold_miss_toggles", 64'(mem_toggles - mt0), 64'd1);

        // Random traffic over 1k addresses with random DDR3 latency.
        ddr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge MCLK);
            issue(20'(($urandom_range(0, 999) * 37) + 5));
            wait_ack(lat);
        end
        repeat (4) @(negedge MCLK);
        check("ack_count", 64'(ack_cnt), 64'(n_req));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("mem_addr_stable", 64'(addr_unstable), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
